magazine_ctl: RTL

Ammunition sequencer for the Duck Hunt game layer. It converts the synchronised mouse-button level into accepted shots and enforces a post-shot cooldown. It also runs the timed reload and refills the magazine at each round start. Its registered `bullets_in_magazine` output drives the bullet HUD renderer in the VGA chain. Its `shot_fired` pulse drives hit detection and scoring.

---
 rtl/game_pkg.sv | 21 ++
 rtl/rise_detect.sv | 20 ++
 rtl/magazine_ctl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared Duck Hunt game-layer types and cycle constants for the 65 MHz pixel clock.
package game_pkg;

  localparam int CLK_HZ                 = 65_000_000;
  localparam int MAG_SIZE_DEF           = 3;
  localparam int COOLDOWN_CYCLES_DEF    = CLK_HZ / 10;      // 100 ms
  localparam int RELOAD_STEP_CYCLES_DEF = (CLK_HZ / 5) * 2; // 0.4 s

  typedef enum logic [2:0] {
    IDLE,
    READY,
    COOLDOWN,
    EMPTY,
    RELOAD
  } mag_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-synchronised level.
// Latency: rise is combinational on the current level against a one-cycle-old copy.
// Backpressure: none; the previous value updates every cycle.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_d;

  always_ff @(posedge clk) begin
    if (rst) in_d <= 1'b0;
    else     in_d <= in;
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/magazine_ctl.sv
// Ammunition sequencer: accepts shots with cooldown, runs timed reload, refills on round start.
// Latency: every input event is reflected on the registered outputs one cycle later.
// Backpressure: none; shots and reloads that arrive when they cannot be honoured are dropped.
module magazine_ctl
  import game_pkg::*;
#(
  parameter int MAG_SIZE           = MAG_SIZE_DEF,
  parameter int COOLDOWN_CYCLES    = COOLDOWN_CYCLES_DEF,
  parameter int RELOAD_STEP_CYCLES = RELOAD_STEP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       mouse_left,
  input  logic       round_start,
  input  logic       reload_req,
  output logic [2:0] bullets_in_magazine,
  output logic       shot_fired,
  output logic       empty,
  output logic       reloading
);

  localparam int TMAX = max_int(COOLDOWN_CYCLES, RELOAD_STEP_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [2:0]    MAG     = 3'(MAG_SIZE);
  localparam logic [TW-1:0] CD_LAST = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0] RL_LAST = TW'(RELOAD_STEP_CYCLES - 1);

  mag_state_e    state, state_nx;
  logic [2:0]    count, count_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          shot_nx, empty_nx, reloading_nx;
  logic          rise;

  // Runs in every state so a button held across enable never looks like a fresh press.
  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (mouse_left),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 3'd0;
      timer      <= '0;
      shot_fired <= 1'b0;
      empty      <= 1'b1;
      reloading  <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      timer      <= timer_nx;
      shot_fired <= shot_nx;
      empty      <= empty_nx;
      reloading  <= reloading_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    timer_nx = timer;
    shot_nx  = 1'b0;
    if (!game_enable) begin
      state_nx = IDLE;
      timer_nx = '0;
    end else if (round_start) begin
      state_nx = READY;
      count_nx = MAG;
      timer_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = (count != 3'd0) ? READY : EMPTY;
        end
        READY: begin
          if (rise && count != 3'd0) begin
            state_nx = COOLDOWN;
            count_nx = count - 3'd1;
            shot_nx  = 1'b1;
            timer_nx = '0;
          end else if (reload_req && count < MAG) begin
            state_nx = RELOAD;
            timer_nx = '0;
          end
        end
        COOLDOWN: begin
          if (timer == CD_LAST) begin
            state_nx = (count != 3'd0) ? READY : EMPTY;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        EMPTY: begin
          if (reload_req) begin
            state_nx = RELOAD;
            timer_nx = '0;
          end
        end
        RELOAD: begin
          if (timer == RL_LAST) begin
            count_nx = count + 3'd1;
            timer_nx = '0;
            if (count + 3'd1 == MAG) state_nx = READY;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Decoded from next values so the flags line up with the registered count.
  always_comb begin
    empty_nx     = (count_nx == 3'd0);
    reloading_nx = (state_nx == RELOAD);
  end

  assign bullets_in_magazine = count;

endmodule
